// File: rtl/ofdm_tx_mapper.sv
// ofdm_tx_mapper: builds one OFDM frequency-domain frame in a single-port spectrum buffer.
// A build clears the whole buffer. It then writes bins 20..120, each followed by its
// Hermitian mirror FFT_LEN-k. Pilots go on bins 20, 21, 54, 87 and 120. The remaining
// bins carry the 96 payload bits as BPSK, MSB-first within each byte.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        request a build (accepted only while idle), data latched on accept
//   data[95:0]   payload
//   clear        clears the sticky finish flag
//   busy         build in progress
//   finish       sticky build-complete flag
//   ce, wre      buffer clock/write enable (always equal)
//   ad[10:0]     buffer address
//   din[31:0]    buffer write data {re, im}, im always zero
module ofdm_tx_mapper #(
    parameter int unsigned FFT_LEN         = 1024,
    parameter logic [15:0] PILOT_AMPLITUDE = 16'h4000,
    parameter logic [15:0] DATA_AMPLITUDE  = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [95:0] data,
    input  logic        clear,
    output logic        busy,
    output logic        finish,
    output logic        ce,
    output logic        wre,
    output logic [10:0] ad,
    output logic [31:0] din
);

    localparam logic [15:0] DataNeg = ~DATA_AMPLITUDE + 16'd1;
    localparam logic [10:0] LastAd  = 11'(FFT_LEN - 1);
    // Truncates to 0 when FFT_LEN = 2048, so 0 - k still yields 2048 - k mod 2^11.
    localparam logic [10:0] LenAd   = 11'(FFT_LEN);
    localparam logic [6:0]  KFirst  = 7'd20;
    localparam logic [6:0]  KLast   = 7'd120;

    typedef enum logic [1:0] {StIdle, StZero, StMap, StDone} state_e;

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         finish_q, finish_d;
    logic         ce_q, ce_d;
    logic [10:0]  ad_q, ad_d;
    logic [31:0]  din_q, din_d;
    logic [95:0]  data_q, data_d;
    logic [6:0]   k_q, k_d;        // current bin
    logic [6:0]   j_q, j_d;        // number of data bins before the current bin
    logic         mirror_q, mirror_d;

    function automatic logic is_pilot(input logic [6:0] k);
        return (k == 7'd20) || (k == 7'd21) || (k == 7'd54) || (k == 7'd87) || (k == 7'd120);
    endfunction

    function automatic logic [31:0] bin_word(input logic [6:0] k, input logic [6:0] j,
                                             input logic [95:0] d);
        logic [6:0] idx;
        logic       bit_v;
        idx   = j ^ 7'd7;  // MSB-first within each byte
        bit_v = (idx < 7'd96) ? d[idx] : 1'b0;
        if (is_pilot(k)) begin
            return {PILOT_AMPLITUDE, 16'h0000};
        end else if (bit_v) begin
            return {DATA_AMPLITUDE, 16'h0000};
        end else begin
            return {DataNeg, 16'h0000};
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        ce_d     = ce_q;
        ad_d     = ad_q;
        din_d    = din_q;
        data_d   = data_q;
        k_d      = k_q;
        j_d      = j_q;
        mirror_d = mirror_q;

        if (clear) begin
            finish_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d   = data;
                    finish_d = 1'b0;
                    busy_d   = 1'b1;
                    ce_d     = 1'b1;
                    ad_d     = 11'd0;
                    din_d    = 32'h0;
                    state_d  = StZero;
                end
            end
            StZero: begin
                if (ad_q == LastAd) begin
                    state_d  = StMap;
                    k_d      = KFirst;
                    j_d      = 7'd0;
                    mirror_d = 1'b0;
                    ad_d     = {4'd0, KFirst};
                    din_d    = bin_word(KFirst, 7'd0, data_q);
                end else begin
                    ad_d = ad_q + 11'd1;
                end
            end
            StMap: begin
                if (!mirror_q) begin
                    ad_d     = LenAd - {4'd0, k_q};
                    mirror_d = 1'b1;
                end else if (k_q == KLast) begin
                    // Set wins over a simultaneous clear.
                    state_d  = StDone;
                    ce_d     = 1'b0;
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    k_d      = k_q + 7'd1;
                    j_d      = j_q + {6'd0, ~is_pilot(k_q)};
                    ad_d     = {4'd0, k_d};
                    din_d    = bin_word(k_d, j_d, data_q);
                    mirror_d = 1'b0;
                end
            end
            StDone: begin
                finish_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            ce_q     <= 1'b0;
            ad_q     <= 11'd0;
            din_q    <= 32'h0;
            data_q   <= 96'h0;
            k_q      <= 7'd0;
            j_q      <= 7'd0;
            mirror_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            ce_q     <= ce_d;
            ad_q     <= ad_d;
            din_q    <= din_d;
            data_q   <= data_d;
            k_q      <= k_d;
            j_q      <= j_d;
            mirror_q <= mirror_d;
        end
    end

    assign busy   = busy_q;
    assign finish = finish_q;
    assign ce     = ce_q;
    assign wre    = ce_q;
    assign ad     = ad_q;
    assign din    = din_q;

endmodule

// File: tb/tb_ofdm_tx_mapper.sv
// Self-checking bench for ofdm_tx_mapper: expected buffer writes are queued when a
// build is started and compared as the DUT emits them; a buffer model is then inspected.
module tb_ofdm_tx_mapper;

    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [95:0] data = 96'h0;
    logic        clear = 1'b0;
    logic        busy, finish, ce, wre;
    logic [10:0] ad;
    logic [31:0] din;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    logic [42:0] sb[$];
    logic [31:0] mem [0:N-1];

    ofdm_tx_mapper dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data   (data),
        .clear  (clear),
        .busy   (busy),
        .finish (finish),
        .ce     (ce),
        .wre    (wre),
        .ad     (ad),
        .din    (din)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit pilot_bin(input int k);
        return (k == 20) || (k == 21) || (k == 54) || (k == 87) || (k == 120);
    endfunction

    // Reference frame: zero pass, then each bin 20..120 and its mirror.
    task automatic push_frame(input logic [95:0] d);
        int j;
        logic [31:0] v;
        for (int a = 0; a < N; a++) sb.push_back({11'(a), 32'h0});
        j = 0;
        for (int k = 20; k <= 120; k++) begin
            if (pilot_bin(k)) begin
                v = 32'h4000_0000;
            end else begin
                v = d[j ^ 7] ? 32'h4000_0000 : 32'hC000_0000;
                j++;
            end
            sb.push_back({11'(k), v});
            sb.push_back({11'(N - k), v});
        end
    endtask

    always @(negedge clk) begin
        logic [42:0] e;
        if (rst_n === 1'b1 && ce === 1'b1) begin
            check("wre_eq_ce", 64'(wre), 64'(1));
            if (sb.size() == 0) begin
                check("sb_empty", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("wr_ad", 64'(ad), 64'(e[42:32]));
                check("wr_din", 64'(din), 64'(e[31:0]));
            end
            if (ad < 11'(N)) mem[ad[9:0]] = din;
            wr_cnt++;
        end
    end

    task automatic run_build(input logic [95:0] d, input bit mid_start, input bit clear_done,
                             input int abort_at, input bit with_clear);
        int cyc;
        push_frame(d);
        wr_cnt = 0;
        start  = 1'b1;
        data   = d;
        clear  = with_clear;
        @(posedge clk); #1;
        start = 1'b0;
        clear = 1'b0;
        cyc   = 1;
        check("busy_c1", 64'(busy), 64'(1));
        check("finish_c1", 64'(finish), 64'(0));
        while (finish !== 1'b1 && cyc < 3000) begin
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                sb.delete();
                check("rst_ce", 64'(ce), 64'(0));
                check("rst_wre", 64'(wre), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_finish", 64'(finish), 64'(0));
                check("rst_ad", 64'(ad), 64'(0));
                return;
            end
            if (cyc == 1226) check("busy_c1226", 64'(busy), 64'(1));
            start = mid_start && (cyc == 100);
            if (start) data = ~d;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("finish_cycle", 64'(cyc), 64'(1227));
        check("busy_at_finish", 64'(busy), 64'(0));
        check("write_count", 64'(wr_cnt), 64'(1226));
        check("sb_drained", 64'(sb.size()), 64'(0));
        clear = clear_done;
        @(posedge clk); #1;
        clear = 1'b0;
        check("finish_after_done", 64'(finish), 64'(1));
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [95:0] d;
        logic [95:0] rec;
        int j;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_finish", 64'(finish), 64'(0));
        check("reset_ce", 64'(ce), 64'(0));
        check("reset_wre", 64'(wre), 64'(0));
        check("reset_ad", 64'(ad), 64'(0));
        check("reset_din", 64'(din), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero payload
        run_build(96'h0, 1'b0, 1'b0, -1, 1'b0);

        // All-ones payload: every bin 20..120 and its mirror is +0.5, the rest zero
        run_build({96{1'b1}}, 1'b0, 1'b0, -1, 1'b0);
        for (int a = 0; a < N; a++) begin
            if ((a >= 20 && a <= 120) || (a >= N - 120 && a <= N - 20))
                check("ones_bin", 64'(mem[a]), 64'h4000_0000);
            else
                check("ones_zero", 64'(mem[a]), 64'h0);
        end

        // Bit ordering: data bit 7 lands on the first data bin
        run_build(96'h80, 1'b0, 1'b0, -1, 1'b0);
        check("order_b22", 64'(mem[22]), 64'h4000_0000);
        check("order_b1002", 64'(mem[1002]), 64'h4000_0000);
        check("order_b29", 64'(mem[29]), 64'hC000_0000);
        check("order_b30", 64'(mem[30]), 64'hC000_0000);
        check("order_b119", 64'(mem[119]), 64'hC000_0000);

        // Loopback: demap the buffer back to bits
        d = {8'h55, $urandom(), $urandom(), 16'($urandom()), 8'h55};
        run_build(d, 1'b0, 1'b0, -1, 1'b0);
        rec = 96'h0;
        j = 0;
        for (int k = 22; k <= 119; k++) begin
            if (!pilot_bin(k)) begin
                rec[j ^ 7] = (mem[k] == 32'h4000_0000);
                check("loop_mirror", 64'(mem[N - k]), 64'(mem[k]));
                j++;
            end
        end
        check("loop_data_lo", 64'(rec[63:0]), 64'(d[63:0]));
        check("loop_data_hi", 64'(rec[95:64]), 64'(d[95:64]));

        // Handshake: mid-build start ignored, clear during DONE loses, then lone clear
        d = 96'hA5A5_0F0F_1234_5678_9ABC_DEF0;
        run_build(d, 1'b1, 1'b1, -1, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("finish_cleared", 64'(finish), 64'(0));

        // Reset mid-build, then a full build started together with clear
        run_build(96'h0123_4567_89AB_CDEF_0F1E_2D3C, 1'b0, 1'b0, 500, 1'b0);
        @(posedge clk); #1;
        run_build(96'hFEDC_BA98_7654_3210_C3C3_3C3C, 1'b0, 1'b0, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ofdm_tx_mapper.md
Name: ofdm_tx_mapper

Overview:
- Transmit-side counterpart of the OFDM demodulator: takes a 96-bit payload and builds the frequency-domain frame in a single-port BSRAM spectrum buffer, which the IFFT block then reads.
- Places BPSK data, fixed pilots and zero bins on the same 50 Hz grid as the receiver: bins 20..120, 1000..6000 Hz.
- Writes Hermitian mirror bins so the IFFT output is real-valued.
- Reports completion with a sticky finish flag, cleared by clear.

Parameters:
- FFT_LEN, 1024: spectrum buffer length in bins; power of two, 256..2048.
- PILOT_AMPLITUDE, 16'h4000: real part written to pilot bins (+0.5, Q1.15).
- DATA_AMPLITUDE, 16'h4000: magnitude of BPSK data bins; bit 1 -> +DATA_AMPLITUDE, bit 0 -> two's-complement negation (16'hC000 at default).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  request frame build; sampled only in IDLE
- data  in  96  payload; latched on accepted start
- clear  in  1  clears finish
- busy  out  1  high from the cycle after start is accepted until the cycle finish rises
- finish  out  1  sticky build-complete flag
- ce  out  1  BSRAM clock enable
- wre  out  1  BSRAM write enable; always equal to ce
- ad  out  11  BSRAM address
- din  out  32  BSRAM write data: {re[15:0], im[15:0]}; im is always 16'h0000

Behaviour:
- Reset (rst_n low at a clk edge):
  - busy, finish, ce, wre = 0; ad = 0; din = 0; latched data = 0; state = IDLE.
  - Reset during a build aborts it. Buffer contents are then undefined; no finish is produced.
- All outputs are registered. One write occurs per cycle in which ce = 1.
- IDLE:
  - On start = 1: latch data, clear finish, set busy, go to ZERO.
  - First write appears on the next cycle.
- ZERO:
  - Writes din = 0 to ad = 0..FFT_LEN-1 on consecutive cycles (FFT_LEN cycles).
  - After the last address, go to MAP.
- MAP:
  - For k = 20..120 ascending, two cycles per bin: ad = k, then ad = FFT_LEN-k, both with the same din. Total 202 cycles.
  - Pilot bins 20, 21, 54, 87, 120: re = PILOT_AMPLITUDE.
  - Data bins are all other k in 22..119. Data index j counts 0..95 in ascending bin order (bins 22..53 -> j 0..31, 55..86 -> 32..63, 88..119 -> 64..95).
  - Bin with index j carries bit data[j ^ 7], i.e. MSB-first within each byte, matching the receiver.
  - After the mirror write of bin 120, go to DONE.
- DONE (1 cycle): ce = wre = 0, busy = 0, finish = 1, go to IDLE.
- Timing: with start accepted at edge E0, writes occupy cycles 1..FFT_LEN+202. finish is high from cycle FFT_LEN+203 (1227 at default).
- Event interactions:
  - start while busy: ignored; the latched data does not change.
  - clear = 1: finish <= 0, except when DONE sets finish in the same cycle (set wins).
  - clear while busy: no effect on the build.
  - start and clear together in IDLE: start accepted, finish = 0.
- Counters: ad and the bin/index counters must not wrap mid-build. The FFT_LEN-1 terminal count uses an 11-bit compare; FFT_LEN = 2048 must terminate at 2047.

Test Plan:
- Zero pass:
  - Stimulus: reset, then start with data = 0.
  - Required: ce = wre = 1 with din = 32'h0 at ad 0..1023 on cycles 1..1024; next cycle ad = 20, din = 32'h4000_0000; next ad = 1004, same din.
- All-ones payload:
  - Stimulus: data = {96{1'b1}}.
  - Required: every data bin k and its mirror FFT_LEN-k hold 32'h4000_0000; pilots hold 32'h4000_0000; all other bins hold 0; finish rises at cycle 1227; busy falls in the same cycle.
- Bit ordering:
  - Stimulus: data = 96'h80 (bit 7 only).
  - Required: bins 22 and 1002 = 32'h4000_0000; bins 29, 30 and all other data bins = 32'hC000_0000.
- Loopback:
  - Stimulus: data with bytes [7:0] = 8'h55 and [95:88] = 8'h55; run the IFFT, then the FFT and the existing demodulator.
  - Required: demodulator result equals data, success = 1.
- Handshake:
  - Stimulus: pulse start at cycle 100 mid-build with a different data; later pulse clear together with the DONE cycle; then clear alone.
  - Required: the cycle-100 start and its data are ignored; finish = 1 after the DONE cycle; finish = 0 one cycle after the lone clear.
- Reset mid-build:
  - Stimulus: drive rst_n = 0 for one edge at cycle 500.
  - Required: next cycle ce = wre = busy = finish = 0 and ad = 0; a subsequent start produces a full, correct 1226-write build.
